// File: rtl/program_sequencer_if.sv
// Control/status bundle between the instruction decoder and the program sequencer.
// master drives the decoded controls; slave is the sequencer itself.
interface program_sequencer_if #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_WIDTH = $clog2(STACK_DEPTH) + 1;

    logic                hold;
    logic                jmp;
    logic                jmp_nz;
    logic                call;
    logic                ret;
    logic                r_eq_0;
    logic [PC_WIDTH-1:0] jmp_addr;
    logic [PC_WIDTH-1:0] pm_addr;
    logic [PC_WIDTH-1:0] pc;
    logic [SP_WIDTH-1:0] sp;
    logic                stack_empty;
    logic                stack_full;
    logic                stack_err;

    modport master (
        output hold, jmp, jmp_nz, call, ret, r_eq_0, jmp_addr,
        input  pm_addr, pc, sp, stack_empty, stack_full, stack_err
    );

    modport slave (
        input  hold, jmp, jmp_nz, call, ret, r_eq_0, jmp_addr,
        output pm_addr, pc, sp, stack_empty, stack_full, stack_err
    );
endinterface

// File: rtl/program_sequencer.sv
// Program counter, next-address selection and hardware return stack for the 4-bit CPU.
// Return stack and call/ret support are built only when SEQ_CALL_STACK_EN is defined.
module program_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    program_sequencer_if.slave bus
);
    localparam int SP_WIDTH  = $clog2(STACK_DEPTH) + 1;
    localparam int IDX_WIDTH = $clog2(STACK_DEPTH);

    logic [PC_WIDTH-1:0] pc_reg;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pm_next;

    assign pc_inc = pc_reg + PC_WIDTH'(1);

`ifdef SEQ_CALL_STACK_EN
    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [SP_WIDTH-1:0] sp_reg;
    logic [SP_WIDTH-1:0] sp_next;
    logic                err_reg;
    logic                err_next;
    logic                push;
    logic                empty;
    logic                full;
    logic [PC_WIDTH-1:0] stack_top;

    assign empty     = (sp_reg == '0);
    assign full      = (sp_reg == SP_WIDTH'(STACK_DEPTH));
    // Depth is a power of two, so the wrapped index when empty stays in range.
    assign stack_top = stack_mem[IDX_WIDTH'(sp_reg - SP_WIDTH'(1))];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_reg  <= '0;
            err_reg <= 1'b0;
        end else begin
            sp_reg  <= sp_next;
            err_reg <= err_next;
        end
    end

    // Contents need no reset; push is forced low while reset is high.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[IDX_WIDTH'(sp_reg)] <= pc_inc;
        end
    end

    assign bus.sp          = sp_reg;
    assign bus.stack_empty = empty;
    assign bus.stack_full  = full;
    assign bus.stack_err   = err_reg;
`else
    logic unused_ctrl;
    assign unused_ctrl     = bus.call | bus.ret;

    assign bus.sp          = '0;
    assign bus.stack_empty = 1'b1;
    assign bus.stack_full  = 1'b0;
    assign bus.stack_err   = 1'b0;
`endif

    // Priority: hold > ret > call > jmp > jmp_nz > increment.
    always_comb begin
        pm_next = pc_inc;
`ifdef SEQ_CALL_STACK_EN
        sp_next  = sp_reg;
        err_next = err_reg;
        push     = 1'b0;
`endif
        if (reset) begin
            pm_next = '0;
        end else if (bus.hold) begin
            pm_next = pc_reg;
`ifdef SEQ_CALL_STACK_EN
        end else if (bus.ret) begin
            if (!empty) begin
                pm_next = stack_top;
                sp_next = sp_reg - SP_WIDTH'(1);
            end else begin
                err_next = 1'b1;
            end
        end else if (bus.call) begin
            if (!full) begin
                push    = 1'b1;
                sp_next = sp_reg + SP_WIDTH'(1);
                pm_next = bus.jmp_addr;
            end else begin
                err_next = 1'b1;
            end
`endif
        end else if (bus.jmp) begin
            pm_next = bus.jmp_addr;
        end else if (bus.jmp_nz && !bus.r_eq_0) begin
            pm_next = bus.jmp_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pm_next;
        end
    end

    assign bus.pm_addr = pm_next;
    assign bus.pc      = pc_reg;
endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: vector tables with expected PC plus a
// reference-model scoreboard for pm_addr/sp/stack flags; adapts to SEQ_CALL_STACK_EN.
module tb_program_sequencer;
    localparam int PW  = 8;
    localparam int SD  = 4;
    localparam int SPW = 3;

    localparam logic [4:0] IDLE = 5'b00000;
    localparam logic [4:0] HOLD = 5'b10000;
    localparam logic [4:0] RET  = 5'b01000;
    localparam logic [4:0] CALL = 5'b00100;
    localparam logic [4:0] JMP  = 5'b00010;
    localparam logic [4:0] JNZ  = 5'b00001;

    typedef struct {
        logic [4:0]    ctl;    // {hold, ret, call, jmp, jmp_nz}
        logic          r0;
        logic [PW-1:0] addr;
        logic [PW-1:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [PW-1:0]  pc;
        logic [SPW-1:0] sp;
        logic           err;
        logic           empty;
        logic           full;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    vec_t tbl[$];
    exp_t sbq[$];

    logic [PW-1:0] m_pc;
    int            m_sp;
    logic          m_err;
    logic [PW-1:0] m_stack [SD];

    always #5 clk = ~clk;

    program_sequencer_if #(.PC_WIDTH(PW), .STACK_DEPTH(SD)) bus ();

    program_sequencer #(.PC_WIDTH(PW), .STACK_DEPTH(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] ctl, input logic r0,
                                input logic [PW-1:0] addr, input logic [PW-1:0] exp_pc);
        vec_t v;
        v.ctl = ctl; v.r0 = r0; v.addr = addr; v.exp_pc = exp_pc;
        return v;
    endfunction

    task automatic model_reset();
        m_pc  = '0;
        m_sp  = 0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input vec_t v, output logic [PW-1:0] pm, output exp_t e);
        logic [PW-1:0] inc;
        inc = m_pc + 8'd1;
        pm  = inc;
        if (v.ctl[4]) begin
            pm = m_pc;
`ifdef SEQ_CALL_STACK_EN
        end else if (v.ctl[3]) begin
            if (m_sp != 0) begin
                m_sp = m_sp - 1;
                pm   = m_stack[m_sp];
            end else begin
                m_err = 1'b1;
            end
        end else if (v.ctl[2]) begin
            if (m_sp != SD) begin
                m_stack[m_sp] = inc;
                m_sp = m_sp + 1;
                pm   = v.addr;
            end else begin
                m_err = 1'b1;
            end
`endif
        end else if (v.ctl[1]) begin
            pm = v.addr;
        end else if (v.ctl[0] && !v.r0) begin
            pm = v.addr;
        end
        m_pc    = pm;
        e.pc    = pm;
        e.sp    = SPW'(m_sp);
        e.err   = m_err;
        e.empty = (m_sp == 0);
        e.full  = (m_sp == SD);
    endtask

    task automatic drive(input vec_t v);
        {bus.hold, bus.ret, bus.call, bus.jmp, bus.jmp_nz} = v.ctl;
        bus.r_eq_0   = v.r0;
        bus.jmp_addr = v.addr;
    endtask

    task automatic check_out(input vec_t v);
        exp_t e;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sbq.pop_front();
        chk("pc", bus.pc, e.pc);
        chk("sp", bus.sp, e.sp);
        chk("stack_err", bus.stack_err, e.err);
        chk("stack_empty", bus.stack_empty, e.empty);
        chk("stack_full", bus.stack_full, e.full);
        $display("txn ctl=%b r0=%b addr=%h -> pc=%h sp=%0d err=%b empty=%b full=%b",
                 v.ctl, v.r0, v.addr, bus.pc, bus.sp, bus.stack_err,
                 bus.stack_empty, bus.stack_full);
    endtask

    // One edge: drive, check zero-latency pm_addr, queue expected state, compare after edge.
    task automatic step(input vec_t v);
        logic [PW-1:0] pm;
        exp_t          e;
        drive(v);
        #1;
        model_step(v, pm, e);
        chk("pm_addr", bus.pm_addr, pm);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        check_out(v);
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            step(tbl[i]);
            chk("table_pc", bus.pc, tbl[i].exp_pc);
        end
        tbl.delete();
    endtask

    // Asynchronous pulse between edges; controls are left as they were.
    task automatic reset_pulse();
        #1;
        reset = 1'b1;
        #1;
        chk("rst_pm_addr", bus.pm_addr, 0);
        chk("rst_pc", bus.pc, 0);
        chk("rst_sp", bus.sp, 0);
        chk("rst_empty", bus.stack_empty, 1);
        chk("rst_full", bus.stack_full, 0);
        chk("rst_err", bus.stack_err, 0);
        model_reset();
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(mk(IDLE, 1'b0, 8'h00, 8'h00));
        model_reset();
        #2;
        chk("init_pm_addr", bus.pm_addr, 0);
        chk("init_pc", bus.pc, 0);
        chk("init_empty", bus.stack_empty, 1);
        chk("init_err", bus.stack_err, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("init_pc_held", bus.pc, 0);
        #2;
        reset = 1'b0;

        for (int i = 1; i <= 5; i++) tbl.push_back(mk(IDLE, 1'b0, 8'h00, 8'(i)));
        run_table();
        reset_pulse();

        tbl.push_back(mk(JMP,  1'b0, 8'hFD, 8'hFD));
        tbl.push_back(mk(IDLE, 1'b0, 8'h00, 8'hFE));
        tbl.push_back(mk(IDLE, 1'b0, 8'h00, 8'hFF));
        tbl.push_back(mk(IDLE, 1'b0, 8'h00, 8'h00));
        tbl.push_back(mk(JMP,  1'b0, 8'h3C, 8'h3C));
        tbl.push_back(mk(JMP,  1'b0, 8'h10, 8'h10));
        tbl.push_back(mk(JNZ,  1'b0, 8'h20, 8'h20));
        tbl.push_back(mk(JMP,  1'b0, 8'h10, 8'h10));
        tbl.push_back(mk(JNZ,  1'b1, 8'h20, 8'h11));
        tbl.push_back(mk(HOLD, 1'b0, 8'h00, 8'h11));
        tbl.push_back(mk(HOLD, 1'b0, 8'h00, 8'h11));
        tbl.push_back(mk(HOLD, 1'b0, 8'h00, 8'h11));
        tbl.push_back(mk(HOLD | CALL | JMP, 1'b0, 8'h55, 8'h11));
        tbl.push_back(mk(HOLD | RET, 1'b0, 8'h00, 8'h11));
        run_table();
        chk("hold_no_err", bus.stack_err, 0);

`ifdef SEQ_CALL_STACK_EN
        tbl.push_back(mk(JMP,  1'b0, 8'h05, 8'h05));
        tbl.push_back(mk(CALL, 1'b0, 8'h40, 8'h40));
        tbl.push_back(mk(IDLE, 1'b0, 8'h00, 8'h41));
        tbl.push_back(mk(CALL, 1'b0, 8'h50, 8'h50));
        tbl.push_back(mk(IDLE, 1'b0, 8'h00, 8'h51));
        tbl.push_back(mk(IDLE, 1'b0, 8'h00, 8'h52));
        tbl.push_back(mk(CALL, 1'b0, 8'h60, 8'h60));
        tbl.push_back(mk(IDLE, 1'b0, 8'h00, 8'h61));
        tbl.push_back(mk(IDLE, 1'b0, 8'h00, 8'h62));
        tbl.push_back(mk(IDLE, 1'b0, 8'h00, 8'h63));
        tbl.push_back(mk(CALL, 1'b0, 8'h70, 8'h70));
        tbl.push_back(mk(IDLE, 1'b0, 8'h00, 8'h71));
        run_table();
        chk("sp_at_full", bus.sp, 4);
        chk("full_flag", bus.stack_full, 1);
        chk("no_err_yet", bus.stack_err, 0);

        tbl.push_back(mk(CALL, 1'b0, 8'h80, 8'h72));
        run_table();
        chk("overflow_err", bus.stack_err, 1);
        chk("overflow_sp", bus.sp, 4);

        tbl.push_back(mk(RET, 1'b0, 8'h00, 8'h64));
        tbl.push_back(mk(RET, 1'b0, 8'h00, 8'h53));
        tbl.push_back(mk(RET, 1'b0, 8'h00, 8'h42));
        tbl.push_back(mk(RET, 1'b0, 8'h00, 8'h06));
        run_table();
        chk("pop_empty", bus.stack_empty, 1);
        reset_pulse();

        tbl.push_back(mk(JMP,  1'b0, 8'h30, 8'h30));
        tbl.push_back(mk(RET,  1'b0, 8'h00, 8'h31));
        tbl.push_back(mk(IDLE, 1'b0, 8'h00, 8'h32));
        tbl.push_back(mk(IDLE, 1'b0, 8'h00, 8'h33));
        run_table();
        chk("underflow_err_sticky", bus.stack_err, 1);
        chk("underflow_sp", bus.sp, 0);

        tbl.push_back(mk(JMP,  1'b0, 8'h20, 8'h20));
        tbl.push_back(mk(CALL, 1'b0, 8'h90, 8'h90));
        tbl.push_back(mk(RET,  1'b0, 8'h00, 8'h21));
        tbl.push_back(mk(JMP,  1'b0, 8'hFF, 8'hFF));
        tbl.push_back(mk(CALL, 1'b0, 8'h10, 8'h10));
        tbl.push_back(mk(RET,  1'b0, 8'h00, 8'h00));
        run_table();
        reset_pulse();
`else
        tbl.push_back(mk(JMP,  1'b0, 8'h05, 8'h05));
        tbl.push_back(mk(CALL, 1'b0, 8'h40, 8'h06));
        run_table();
        chk("nostack_sp", bus.sp, 0);
        chk("nostack_err", bus.stack_err, 0);
        tbl.push_back(mk(RET, 1'b0, 8'h00, 8'h07));
        tbl.push_back(mk(CALL | JMP, 1'b0, 8'h33, 8'h33));
        tbl.push_back(mk(RET | JNZ, 1'b0, 8'h44, 8'h44));
        tbl.push_back(mk(RET | JNZ, 1'b1, 8'h44, 8'h45));
        run_table();
        chk("nostack_err_end", bus.stack_err, 0);
        chk("nostack_empty", bus.stack_empty, 1);
`endif

        // Reset held across an edge while a call is requested: nothing is pushed.
        tbl.push_back(mk(JMP, 1'b0, 8'h05, 8'h05));
        run_table();
        drive(mk(CALL, 1'b0, 8'h77, 8'h00));
        #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_call_pc", bus.pc, 0);
        chk("rst_call_sp", bus.sp, 0);
        chk("rst_call_pm", bus.pm_addr, 0);
        reset = 1'b0;
        tbl.push_back(mk(IDLE, 1'b0, 8'h00, 8'h01));
        run_table();
        chk("rst_call_empty", bus.stack_empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/program_sequencer.md
# program_sequencer

Program sequencer for the 4-bit microprocessor: holds the program counter, computes the next program-memory address each cycle, and resolves unconditional jumps, conditional jumps on the computational unit's `r_eq_0` flag, and subroutine call/return through a small hardware return stack. It sits directly upstream of the instruction decoder and computational unit. It drives the synchronous program ROM address, and the ROM's registered instruction feeds the decoder that produces `nibble_ir`, `source_sel` and `reg_en`.

## Interface
Parameters:
- `PC_WIDTH`, 8, width of program counter and ROM address
- `STACK_DEPTH`, 4, number of return-stack entries (power of two, ≥2)

Ports:
- `clk` input 1: single system clock, rising edge
- `reset` input 1: asynchronous, active-high; clears all state immediately
- `hold` input 1: stall; freezes PC and stack
- `jmp` input 1: unconditional jump to `jmp_addr`
- `jmp_nz` input 1: jump to `jmp_addr` when `r_eq_0 == 0`
- `call` input 1: push return address, jump to `jmp_addr`
- `ret` input 1: pop return address into PC
- `r_eq_0` input 1: zero flag from computational unit
- `jmp_addr` input PC_WIDTH: target address from decoded instruction
- `pm_addr` output PC_WIDTH: combinational next address to program ROM
- `pc` output PC_WIDTH: registered current program counter
- `sp` output log2(STACK_DEPTH)+1: stack occupancy, 0..STACK_DEPTH
- `stack_empty` output 1: `sp == 0`
- `stack_full` output 1: `sp == STACK_DEPTH`
- `stack_err` output 1: sticky overflow/underflow flag

## Operation
- `pm_addr` is combinational from `pc`, the control inputs and the stack top. `pc <= pm_addr` on every rising edge.
- Control priority is `hold` > `ret` > `call` > `jmp` > `jmp_nz` > increment. Only the highest-priority asserted control acts.
  - `hold`: `pm_addr = pc`; PC, stack and `stack_err` unchanged.
  - `ret`, stack not empty: `pm_addr = stack[sp-1]`; `sp` decrements.
  - `ret`, stack empty: `pm_addr = pc+1`; `stack_err` set; `sp` stays 0.
  - `call`, stack not full: `stack[sp] <= pc+1`; `sp` increments; `pm_addr = jmp_addr`.
  - `call`, stack full: the call is suppressed. `pm_addr = pc+1`, `stack_err` set, stack unchanged.
  - `jmp`: `pm_addr = jmp_addr`.
  - `jmp_nz`: `pm_addr = jmp_addr` if `r_eq_0 == 0`, else `pc+1`.
  - None asserted: `pm_addr = pc+1`.
- Increment is modulo 2^PC_WIDTH: `pc = {PC_WIDTH{1}}` increments to 0. The pushed return address wraps the same way.
- `stack_err` is sticky and cleared only by `reset`.
- While `reset` is high: `pm_addr = 0`, `pc = 0`, `sp = 0`, `stack_empty = 1`, `stack_full = 0`, `stack_err = 0`. Stack contents are don't-care.
- Reset asserted mid-call or mid-return discards the in-flight update; no partial push or pop.

## Timing
- `pm_addr` depends on the current-cycle controls (zero-cycle latency). The ROM registers it, so the instruction at `pm_addr` appears one cycle later.
- `pc`, `sp`, `stack_err` and the stack update at the same edge that consumes `pm_addr`.
- Reset deasserts asynchronously. The ROM has sampled `pm_addr = 0` during reset, so the instruction at address 0 is present at the first edge after release.
  - With no control asserted, `pc` reads 1 after that edge.
- A `call` immediately followed by a `ret` returns to call-site+1 two edges after the call.
- `r_eq_0` is sampled combinationally in the cycle `jmp_nz` is asserted. The computational unit must have registered the flag at least one edge earlier.

## Configuration
- Macro `SEQ_CALL_STACK_EN`.
- Defined: return stack, `call`/`ret` and `stack_err` behave as above.
- Undefined: no stack storage is built. `call` and `ret` are ignored and fall through the priority chain to the next asserted control or increment. `sp = 0`, `stack_empty = 1`, `stack_full = 0`, `stack_err = 0` constantly.

## Test plan
- Reset, then 5 idle edges: `pm_addr` is 0 during reset, then `pc` = 1,2,3,4,5. Assert `reset` asynchronously between edges: `pc` reads 0 at once.
- Run to `pc = 8'hFF`, idle edge: `pc = 8'h00`. Then `jmp` with `jmp_addr = 8'h3C`: `pm_addr = 8'h3C` the same cycle, `pc = 8'h3C` next edge.
- `jmp_nz` with `jmp_addr = 8'h20`, `r_eq_0 = 0` at `pc = 8'h10`: `pc = 8'h20`. Repeat at `pc = 8'h10` with `r_eq_0 = 1`: `pc = 8'h11`. `hold` held 3 cycles: `pc` unchanged.
- Calls at `pc` = 0x05, 0x41, 0x52, 0x63 to `jmp_addr` 0x40, 0x50, 0x60, 0x70: `sp` reaches 4, `stack_full = 1`.
  - Fifth call at `pc = 8'h71`: `pc = 8'h72`, `stack_err = 1`.
  - Four `ret`: `pc` = 0x64, 0x53, 0x42, 0x06, `stack_empty = 1`.
- `ret` on empty stack at `pc = 8'h30`: `pc = 8'h31`, `stack_err = 1` until reset. `call`+`jmp`+`hold` together: hold wins, `pc` unchanged.
- Build without `SEQ_CALL_STACK_EN`: `call` with `jmp_addr = 8'h40` at `pc = 8'h05`: `pc = 8'h06`, `sp = 0`, `stack_err = 0`.
